// File: rtl/fpu_pkg.sv
// FP32 field layout, FCLASS.S class-bit indices and the result-buffer state
// type, shared by the fclass_arb arbiter and its classify core.
package fpu_pkg;

    // FP32 field positions
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_W    = 23;
    localparam int QNAN_BIT = 22;

    localparam logic [7:0] EXP_ALL1 = 8'hFF;

    // FCLASS.S one-hot result bit positions
    localparam int CLS_NINF  = 0;
    localparam int CLS_NNORM = 1;
    localparam int CLS_NSUB  = 2;
    localparam int CLS_NZERO = 3;
    localparam int CLS_PZERO = 4;
    localparam int CLS_PSUB  = 5;
    localparam int CLS_PNORM = 6;
    localparam int CLS_PINF  = 7;
    localparam int CLS_SNAN  = 8;
    localparam int CLS_QNAN  = 9;
    localparam int CLS_W     = 10;

    // Single-entry result buffer occupancy
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // True when a class mask reports either kind of NaN
    function automatic logic is_nan_mask(input logic [CLS_W-1:0] mask);
        return mask[CLS_SNAN] | mask[CLS_QNAN];
    endfunction

endpackage

// File: rtl/fclass_arb_if.sv
// Request/response handshake bundle for fclass_arb. The master side is the
// requesters plus the result consumer; the slave side is the arbiter.
interface fclass_arb_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req0_valid;
    logic             req0_ready;
    logic [XLEN-1:0]  req0_a;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [XLEN-1:0]  req1_a;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [XLEN-1:0]  rsp_data;

    modport master (
        output req0_valid, req0_a, req0_tag,
        output req1_valid, req1_a, req1_tag,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_data
    );

    modport slave (
        input  req0_valid, req0_a, req0_tag,
        input  req1_valid, req1_a, req1_tag,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_data
    );
endinterface

// File: rtl/fclass_core.sv
// Combinational RISC-V FCLASS.S: FP32 operand in, 10-bit one-hot class out.
module fclass_core
    import fpu_pkg::*;
(
    input  logic [31:0]      a_i,
    output logic [CLS_W-1:0] mask_o
);

    logic             sign_s;
    logic [7:0]       exp_s;
    logic [MAN_W-1:0] man_s;
    logic             exp_all1_s;
    logic             exp_zero_s;
    logic             man_zero_s;

    assign sign_s     = a_i[SIGN_BIT];
    assign exp_s      = a_i[EXP_MSB:EXP_LSB];
    assign man_s      = a_i[MAN_W-1:0];
    assign exp_all1_s = (exp_s == EXP_ALL1);
    assign exp_zero_s = (exp_s == 8'h00);
    assign man_zero_s = (man_s == {MAN_W{1'b0}});

    // Decode the exponent/mantissa category, then place it by sign (NaNs ignore sign)
    always_comb begin
        mask_o = {CLS_W{1'b0}};
        if (exp_all1_s) begin
            if (man_zero_s) begin
                if (sign_s) begin
                    mask_o[CLS_NINF] = 1'b1;
                end else begin
                    mask_o[CLS_PINF] = 1'b1;
                end
            end else if (man_s[QNAN_BIT]) begin
                mask_o[CLS_QNAN] = 1'b1;
            end else begin
                mask_o[CLS_SNAN] = 1'b1;
            end
        end else if (exp_zero_s) begin
            if (man_zero_s) begin
                if (sign_s) begin
                    mask_o[CLS_NZERO] = 1'b1;
                end else begin
                    mask_o[CLS_PZERO] = 1'b1;
                end
            end else begin
                if (sign_s) begin
                    mask_o[CLS_NSUB] = 1'b1;
                end else begin
                    mask_o[CLS_PSUB] = 1'b1;
                end
            end
        end else begin
            if (sign_s) begin
                mask_o[CLS_NNORM] = 1'b1;
            end else begin
                mask_o[CLS_PNORM] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fclass_arb.sv
// Two-requester round-robin front end for a shared FCLASS.S datapath with a
// single-entry registered result buffer (1-cycle latency, full throughput).
// Optional build macro FCLASS_NAN_CNT_EN adds a saturating NaN-result counter;
// without it nan_cnt is tied to zero and no counter flops exist.
module fclass_arb
    import fpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
)(
    input  logic         clk,
    input  logic         rst_n,
    fclass_arb_if.slave  bus,
    output logic [15:0]  nan_cnt
);

    buf_state_e       state_q;
    logic             rr_q;
    logic             rsp_id_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [XLEN-1:0]  rsp_data_q;

    logic             can_accept_s;
    logic             gnt0_s;
    logic             gnt1_s;
    logic             accept_s;
    logic [31:0]      op_a_s;
    logic [TAG_W-1:0] op_tag_s;
    logic [CLS_W-1:0] mask_s;

    // Round-robin grant among valid requesters; rr only matters under contention
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt0_s = ~rr_q;
            gnt1_s = rr_q;
        end else begin
            gnt0_s = bus.req0_valid;
            gnt1_s = bus.req1_valid;
        end
    end

    // Buffer can take a new result when empty or when it is draining this cycle
    assign can_accept_s   = (state_q == BUF_EMPTY) | bus.rsp_ready;
    assign accept_s       = can_accept_s & (gnt0_s | gnt1_s);
    assign bus.req0_ready = rst_n & can_accept_s & gnt0_s;
    assign bus.req1_ready = rst_n & can_accept_s & gnt1_s;

    // Steer the winning operand and tag into the single classify core
    always_comb begin
        op_a_s   = 32'h0000_0000;
        op_tag_s = {TAG_W{1'b0}};
        if (gnt1_s) begin
            op_a_s   = bus.req1_a[31:0];
            op_tag_s = bus.req1_tag;
        end else begin
            op_a_s   = bus.req0_a[31:0];
            op_tag_s = bus.req0_tag;
        end
    end

    fclass_core u_core (
        .a_i    (op_a_s),
        .mask_o (mask_s)
    );

    // Result-buffer FSM: load on accept, hold under backpressure, empty on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUF_EMPTY;
            rr_q       <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_tag_q  <= {TAG_W{1'b0}};
            rsp_data_q <= {XLEN{1'b0}};
        end else begin
            if (accept_s) begin
                rr_q       <= gnt0_s;
                rsp_id_q   <= gnt1_s;
                rsp_tag_q  <= op_tag_s;
                rsp_data_q <= XLEN'(mask_s);
            end else begin
                rr_q <= rr_q;
            end
            case (state_q)
                BUF_EMPTY: begin
                    if (accept_s) begin
                        state_q <= BUF_FULL;
                    end else begin
                        state_q <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (accept_s) begin
                        state_q <= BUF_FULL;
                    end else if (bus.rsp_ready) begin
                        state_q <= BUF_EMPTY;
                    end else begin
                        state_q <= BUF_FULL;
                    end
                end
                default: begin
                    state_q <= BUF_EMPTY;
                end
            endcase
        end
    end

    assign bus.rsp_valid = (state_q == BUF_FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_data  = rsp_data_q;

`ifdef FCLASS_NAN_CNT_EN
    logic [15:0] nan_cnt_q;

    // Count accepted operands that classify as NaN, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_cnt_q <= 16'h0000;
        end else if (accept_s && is_nan_mask(mask_s) && (nan_cnt_q != 16'hFFFF)) begin
            nan_cnt_q <= nan_cnt_q + 16'h0001;
        end else begin
            nan_cnt_q <= nan_cnt_q;
        end
    end

    assign nan_cnt = nan_cnt_q;
`else
    assign nan_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fclass_arb.sv
// Scoreboard bench for fclass_arb: the driver predicts grants and pushes the
// expected response; an independent monitor pops and compares.
module tb_fclass_arb;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic        id;
        logic [4:0]  tag;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] nan_cnt;

    int   errors = 0;
    int   checks = 0;
    rsp_t exp_q[$];
    int   m_rr = 0;
    int   m_full = 0;
    int   m_nan = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    fclass_arb_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    fclass_arb #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .nan_cnt (nan_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference FCLASS from the category rules: positives mirror negatives
    function automatic logic [31:0] ref_class(input logic [31:0] a);
        int e;
        int m;
        int cat;
        e = int'(a[30:23]);
        m = int'(a[22:0]);
        if (e == 255 && m != 0) return a[22] ? 32'd512 : 32'd256;
        if (e == 255)     cat = 0;
        else if (e == 0 && m == 0) cat = 3;
        else if (e == 0)  cat = 2;
        else              cat = 1;
        return 32'd1 << (a[31] ? cat : 7 - cat);
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r[30:23] = 8'hFF;
            1: r[30:23] = 8'h00;
            2: begin r[30:23] = 8'hFF; r[22:0] = 23'h0; end
            3: r[30:0] = 31'h0;
            4: begin r[30:23] = 8'hFF; r[22] = 1'b0; end
            default: ;
        endcase
        return r;
    endfunction

    // One clock of stimulus with grant prediction and expected-response push
    task automatic do_cycle(input logic v0, input logic [31:0] a0, input logic [4:0] t0,
                            input logic v1, input logic [31:0] a1, input logic [4:0] t1,
                            input logic rdy, output logic acc0, output logic acc1);
        bit   can;
        int   w;
        rsp_t e;
        @(negedge clk);
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_tag = t0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_tag = t1;
        bus.rsp_ready  = rdy;
        #1;
        can = (m_full == 0) || rdy;
        w = -1;
        if (v0 && v1) w = m_rr;
        else if (v0) w = 0;
        else if (v1) w = 1;
        acc0 = can && (w == 0);
        acc1 = can && (w == 1);
        check("req0_ready", {31'b0, bus.req0_ready}, {31'b0, acc0});
        check("req1_ready", {31'b0, bus.req1_ready}, {31'b0, acc1});
        @(posedge clk);
        #1;
        if (acc0 || acc1) begin
            e.id   = acc1;
            e.tag  = acc1 ? t1 : t0;
            e.data = ref_class(acc1 ? a1 : a0);
            exp_q.push_back(e);
            m_rr   = acc1 ? 0 : 1;
            m_full = 1;
`ifdef FCLASS_NAN_CNT_EN
            if ((e.data & 32'h300) != 32'h0 && m_nan < 65535) m_nan++;
`endif
        end else if (rdy) begin
            m_full = 0;
        end
        check("nan_cnt", {16'b0, nan_cnt}, m_nan[31:0]);
    endtask

    // Async reset with valids held high to show ready is gated off
    task automatic do_reset();
        mon_en = 1'b0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        check("rst_rsp_id",    {31'b0, bus.rsp_id},    32'h0);
        check("rst_rsp_tag",   {27'b0, bus.rsp_tag},   32'h0);
        check("rst_rsp_data",  bus.rsp_data,           32'h0);
        check("rst_req0_ready", {31'b0, bus.req0_ready}, 32'h0);
        check("rst_req1_ready", {31'b0, bus.req1_ready}, 32'h0);
        check("rst_nan_cnt",   {16'b0, nan_cnt},       32'h0);
        exp_q.delete();
        m_rr = 0; m_full = 0; m_nan = 0;
        repeat (2) @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    // Random or forced-contention traffic; a requester holds until accepted
    task automatic drive_n(input int n, input bit both, input int rdy_pct);
        logic v0 = 1'b0, v1 = 1'b0, acc0 = 1'b0, acc1 = 1'b0, rdy;
        logic [31:0] a0 = 32'h0, a1 = 32'h0;
        logic [4:0]  t0 = 5'h0, t1 = 5'h0;
        for (int i = 0; i < n; i++) begin
            if (!v0 || acc0) begin
                v0 = both ? 1'b1 : ($urandom_range(0, 99) < 60);
                a0 = rand_op(); t0 = 5'($urandom_range(0, 31));
            end
            if (!v1 || acc1) begin
                v1 = both ? 1'b1 : ($urandom_range(0, 99) < 60);
                a1 = rand_op(); t1 = 5'($urandom_range(0, 31));
            end
            rdy = ($urandom_range(0, 99) < rdy_pct);
            do_cycle(v0, a0, t0, v1, a1, t1, rdy, acc0, acc1);
        end
    endtask

    // Monitor: compare the presented response with the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, (exp_q.size() != 0)});
                if (exp_q.size() != 0) begin
                    check("rsp_id",   {31'b0, bus.rsp_id},  {31'b0, exp_q[0].id});
                    check("rsp_tag",  {27'b0, bus.rsp_tag}, {27'b0, exp_q[0].tag});
                    check("rsp_data", bus.rsp_data,         exp_q[0].data);
                    if (bus.rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    logic [31:0] sweep_a [9];
    logic [31:0] sweep_x [9];
    logic        k0, k1;

    initial begin
        sweep_a = '{32'h80000200, 32'h80000000, 32'h00000000, 32'h00000200, 32'h10000200,
                    32'h7F800000, 32'h7FA00000, 32'h7FC00000, 32'h90000200};
        sweep_x = '{32'h004, 32'h008, 32'h010, 32'h020, 32'h040,
                    32'h080, 32'h100, 32'h200, 32'h002};
        bus.req0_valid = 1'b0; bus.req0_a = 32'h0; bus.req0_tag = 5'h0;
        bus.req1_valid = 1'b0; bus.req1_a = 32'h0; bus.req1_tag = 5'h0;
        bus.rsp_ready  = 1'b0;
        #3;
        do_reset();

        // Single requester, -inf
        do_cycle(1'b1, 32'hFF800000, 5'd3, 1'b0, 32'h0, 5'd0, 1'b1, k0, k1);
        check("single_data", bus.rsp_data, 32'h001);
        check("single_tag",  {27'b0, bus.rsp_tag}, 32'd3);
        do_cycle(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, k0, k1);

        // Class sweep on requester 1, back to back
        for (int i = 0; i < 9; i++) begin
            do_cycle(1'b0, 32'h0, 5'd0, 1'b1, sweep_a[i], 5'(i), 1'b1, k0, k1);
            check("sweep_data", bus.rsp_data, sweep_x[i]);
        end
        do_cycle(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, k0, k1);

        // Contention from reset: alternating grants, no bubbles
        do_reset();
        drive_n(8, 1'b1, 100);
        do_cycle(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, k0, k1);

        // Backpressure then same-edge drain and refill
        do_cycle(1'b1, 32'h3F800000, 5'd1, 1'b0, 32'h0, 5'd0, 1'b1, k0, k1);
        for (int i = 0; i < 3; i++)
            do_cycle(1'b1, 32'hBF800000, 5'd2, 1'b1, 32'h7FC00000, 5'd4, 1'b0, k0, k1);
        do_cycle(1'b1, 32'hBF800000, 5'd2, 1'b1, 32'h7FC00000, 5'd4, 1'b1, k0, k1);
        do_cycle(1'b1, 32'hBF800000, 5'd2, 1'b0, 32'h0, 5'd0, 1'b1, k0, k1);
        do_cycle(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, k0, k1);

        // Reset while the buffer is full; requester 0 must win afterwards
        do_cycle(1'b0, 32'h0, 5'd0, 1'b1, 32'h7F800000, 5'd9, 1'b0, k0, k1);
        check("full_before_rst", {31'b0, bus.rsp_valid}, 32'h1);
        do_reset();
        do_cycle(1'b1, 32'h7FC00000, 5'd5, 1'b1, 32'h00000001, 5'd6, 1'b1, k0, k1);
        check("post_rst_winner", {31'b0, bus.rsp_id}, 32'h0);
        do_cycle(1'b1, 32'h7FA00000, 5'd7, 1'b1, 32'h00000001, 5'd6, 1'b1, k0, k1);
        do_cycle(1'b1, 32'h7FA00000, 5'd7, 1'b0, 32'h0, 5'd0, 1'b1, k0, k1);
        do_cycle(1'b1, 32'h3F800000, 5'd8, 1'b0, 32'h0, 5'd0, 1'b1, k0, k1);
        do_cycle(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, k0, k1);
`ifdef FCLASS_NAN_CNT_EN
        check("nan_cnt_fixed", {16'b0, nan_cnt}, 32'd2);
`else
        check("nan_cnt_fixed", {16'b0, nan_cnt}, 32'd0);
`endif

        // Randomized traffic with random backpressure
        drive_n(400, 1'b0, 65);
        for (int i = 0; i < 3; i++)
            do_cycle(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, k0, k1);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fclass_arb.md
Name: fclass_arb

Overview:
- Shares one FP32 classify datapath (RISC-V FCLASS.S) between two requesters.
  - Requester 0: FP execute pipe.
  - Requester 1: FP exception/trap handler.
- Round-robin arbitration; valid/ready on both input ports and on the response port.
- Result is registered in a single-entry output buffer: 1-cycle latency, 1 op/cycle sustained.

Parameters:
- XLEN, 32, width of operand and result data (FP32 operand; FCLASS result zero-extended to XLEN).
- TAG_W, 5, width of the destination-register tag carried with each request.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operand
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  XLEN  requester 0 FP32 operand
- req0_tag  in  TAG_W  requester 0 tag
- req1_valid  in  1  requester 1 has an operand
- req1_ready  out  1  requester 1 accepted this cycle
- req1_a  in  XLEN  requester 1 FP32 operand
- req1_tag  in  TAG_W  requester 1 tag
- rsp_valid  out  1  result buffer holds a result
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that owns the result
- rsp_tag  out  TAG_W  tag of the result
- rsp_data  out  XLEN  classify mask, bits [9:0]; bits [XLEN-1:10] = 0
- nan_cnt  out  16  NaN-result counter (optional feature)

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0; rsp_id, rsp_tag, rsp_data=0.
  - Round-robin pointer rr=0; nan_cnt=0.
  - req*_ready=0 while rst_n=0.
- Buffer states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = EMPTY | (FULL & rsp_ready).
  - Permits same-cycle drain-and-refill with no bubble.
- Grant, combinational in the cycle:
  - Only one valid: that requester wins.
  - Both valid: requester rr wins.
  - req_ready[g] = can_accept & winner==g; the loser's ready=0.
  - A requester must hold valid and data stable until ready is seen.
- On accept at edge k:
  - Buffer loads class(a), winner id and tag; rsp_valid=1 after edge k.
  - rr <= ~winner.
  - No accept: rr unchanged.
- FULL & !rsp_ready: buffer holds all outputs stable; both ready=0.
- FULL & rsp_ready & no request: buffer goes EMPTY.
- Classify mask, exactly one bit set (s=sign, e=exp[30:23], m=man[22:0]):
  - bit0: -inf (s=1, e=FF, m=0)
  - bit1: -normal (s=1, e in 01..FE)
  - bit2: -subnormal (s=1, e=0, m!=0)
  - bit3: -0
  - bit4: +0
  - bit5: +subnormal
  - bit6: +normal
  - bit7: +inf
  - bit8: signalling NaN (e=FF, m!=0, m[22]=0)
  - bit9: quiet NaN (e=FF, m[22]=1)
  - Sign is ignored for NaNs.
- Upper operand bits above 31 (XLEN>32): ignored, no NaN-box check.

Optional Feature:
- Macro FCLASS_NAN_CNT_EN.
- Defined:
  - nan_cnt increments by 1 on each accepted operand that classifies as sNaN or qNaN.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: nan_cnt tied to 16'h0000 and no counter flops are built.
- Port list is identical in both builds.

Decomposition:
- Package fpu_pkg holds:
  - FP32 field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_W=23, QNAN_BIT=22.
  - EXP_ALL1=8'hFF.
  - Class bit indices CLS_NINF..CLS_QNAN (0..9).
  - CLS_W=10.
- Sub-module fclass_core: purely combinational, FP32 in, 10-bit one-hot mask out. It is instantiated once after the grant mux.

Test Plan:
- Single requester: req0 a=32'hFF800000 tag=3, rsp_ready=1 → next cycle rsp_valid=1, rsp_data=32'h001, rsp_id=0, rsp_tag=3.
- Class sweep on req1: 80000200→004, 80000000→008, 00000000→010, 00000200→020, 10000200→040, 7F800000→080, 7FA00000→100, 7FC00000→200, 90000200→002.
- Contention: both valid every cycle from reset, rsp_ready=1 → grants alternate 0,1,0,1; one result every cycle with no bubble.
- Backpressure: buffer FULL, rsp_ready=0 for 3 cycles → rsp_* stable and both ready=0; rsp_ready=1 with a request pending → drain and refill on the same edge.
- Reset mid-op: assert rst_n=0 asynchronously while FULL → rsp_valid drops immediately with no clock edge; after release, rr=0, so requester 0 wins first contention.
- FCLASS_NAN_CNT_EN defined: accept 7FC00000, 7FA00000, 3F800000 → nan_cnt=2. Without the macro, nan_cnt stays 0.
